keypad_scanner_4x4: RTL

- Input-side counterpart of the 4-digit hex display driver.
- Scans a 4x4 matrix hex keypad, column by column, with active-low column drive and active-low row sense.
- Synchronises and debounces the row inputs, then decodes a single keypress into a 4-bit hex code.
- Shifts each accepted code into a 16-bit `hexx` buffer that feeds the display driver's `hexx` input directly.

---
 rtl/keypad_pkg.sv | 35 +++
 rtl/sync_2ff.sv | 21 ++
 rtl/keypad_scanner_4x4.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and key decoding for the 4x4 hex keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2
    } scan_state_t;

    // Indexed by {row, col}; entry 0 is row 0 / column 0.
    localparam logic [15:0][3:0] KEYMAP = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        return KEYMAP[{row, col}];
    endfunction

    // Lowest active-low row index wins when several rows are pulled down.
    function automatic logic [1:0] lowest_row(input logic [3:0] rows_n);
        if (!rows_n[0]) begin
            return 2'd0;
        end else if (!rows_n[1]) begin
            return 2'd1;
        end else if (!rows_n[2]) begin
            return 2'd2;
        end else begin
            return 2'd3;
        end
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Reset-free two-flop synchroniser for asynchronous pad inputs.
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Metastability settling chain.
    always_ff @(posedge clk) begin
        r_meta <= i_d;
        r_sync <= r_meta;
    end

    assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner_4x4.sv
// 4x4 matrix keypad scanner with debounce and a 4-digit hex entry buffer.
// Optional auto-repeat while a key stays down: define KEYPAD_AUTOREPEAT_EN.
module keypad_scanner_4x4
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV_LOG2  = 15,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_TICKS   = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  rows,
    output logic [3:0]  cols,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        key_held,
    output logic [15:0] hexx
);

    localparam logic [3:0] DB_LIMIT = 4'(DEBOUNCE_SCANS);
    localparam logic [SCAN_DIV_LOG2-1:0] PRESC_ONE = {{(SCAN_DIV_LOG2-1){1'b0}}, 1'b1};

    logic [SCAN_DIV_LOG2-1:0] r_presc;
    logic        w_tick;
    logic [3:0]  w_rows;
    scan_state_t r_state,    w_state_nx;
    logic [1:0]  r_col_idx,  w_col_nx;
    logic [1:0]  r_cand_col, w_cand_col_nx;
    logic [1:0]  r_cand_row, w_cand_row_nx;
    logic [3:0]  r_cnt,      w_cnt_nx;
    logic        r_key_valid, w_valid_nx;
    logic [3:0]  r_key_code, w_code_nx;
    logic        r_key_held, w_held_nx;
    logic [15:0] r_hexx,     w_hexx_nx;
    logic [3:0]  r_cols;
    logic        w_cand_low;
    logic [3:0]  w_cand_key;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam logic [15:0] REP_LIMIT = 16'(REPEAT_TICKS);
    logic [15:0] r_rep, w_rep_nx;
`else
    logic w_unused_repeat;
    assign w_unused_repeat = (REPEAT_TICKS != 32'sd0);
`endif

    sync_2ff #(.WIDTH(4)) u_rows_sync (
        .clk (clk),
        .i_d (rows),
        .o_q (w_rows)
    );

    assign w_tick     = en & (r_presc == {SCAN_DIV_LOG2{1'b1}});
    assign w_cand_low = ~w_rows[r_cand_row];
    assign w_cand_key = key_lookup(r_cand_row, r_cand_col);

    // Column dwell prescaler; held at zero while scanning is disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
        end else if (!en) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PRESC_ONE;
        end
    end

    // Scan/debounce next-state; rows are only looked at on a tick.
    always_comb begin
        w_state_nx    = r_state;
        w_col_nx      = r_col_idx;
        w_cand_col_nx = r_cand_col;
        w_cand_row_nx = r_cand_row;
        w_cnt_nx      = r_cnt;
        w_valid_nx    = 1'b0;
        w_code_nx     = r_key_code;
        w_held_nx     = r_key_held;
        w_hexx_nx     = r_hexx;
`ifdef KEYPAD_AUTOREPEAT_EN
        w_rep_nx      = r_rep;
`endif
        if (!en) begin
            w_state_nx = SCAN;
            w_col_nx   = 2'd0;
            w_cnt_nx   = 4'd0;
            w_held_nx  = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            w_rep_nx   = 16'd0;
`endif
        end else if (w_tick) begin
            case (r_state)
                SCAN: begin
                    if (w_rows == 4'b1111) begin
                        w_col_nx = r_col_idx + 2'd1;
                    end else begin
                        w_cand_col_nx = r_col_idx;
                        w_cand_row_nx = lowest_row(w_rows);
                        w_cnt_nx      = 4'd1;
                        w_state_nx    = PRESS_DB;
                    end
                end
                PRESS_DB: begin
                    if (!w_cand_low) begin
                        w_state_nx = SCAN;
                        w_col_nx   = r_cand_col + 2'd1;
                    end else if (r_cnt + 4'd1 == DB_LIMIT) begin
                        w_valid_nx = 1'b1;
                        w_code_nx  = w_cand_key;
                        w_hexx_nx  = {r_hexx[11:0], w_cand_key};
                        w_held_nx  = 1'b1;
                        w_cnt_nx   = 4'd0;
                        w_state_nx = HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                        w_rep_nx   = 16'd0;
`endif
                    end else begin
                        w_cnt_nx = r_cnt + 4'd1;
                    end
                end
                HELD: begin
                    if (w_cand_low) begin
                        w_cnt_nx = 4'd0;
`ifdef KEYPAD_AUTOREPEAT_EN
                        if (r_rep + 16'd1 == REP_LIMIT) begin
                            w_valid_nx = 1'b1;
                            w_hexx_nx  = {r_hexx[11:0], r_key_code};
                            w_rep_nx   = 16'd0;
                        end else begin
                            w_rep_nx = r_rep + 16'd1;
                        end
`endif
                    end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
                        w_rep_nx = 16'd0;
`endif
                        if (r_cnt + 4'd1 == DB_LIMIT) begin
                            w_held_nx  = 1'b0;
                            w_cnt_nx   = 4'd0;
                            w_state_nx = SCAN;
                            w_col_nx   = r_cand_col + 2'd1;
                        end else begin
                            w_cnt_nx = r_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    w_state_nx = SCAN;
                    w_col_nx   = 2'd0;
                    w_cnt_nx   = 4'd0;
                end
            endcase
        end else begin
            w_state_nx = r_state;
        end
    end

    // Scanner state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= SCAN;
            r_col_idx   <= 2'd0;
            r_cand_col  <= 2'd0;
            r_cand_row  <= 2'd0;
            r_cnt       <= 4'd0;
            r_key_valid <= 1'b0;
            r_key_code  <= 4'd0;
            r_key_held  <= 1'b0;
            r_hexx      <= 16'h0000;
            r_cols      <= 4'b1111;
        end else begin
            r_state     <= w_state_nx;
            r_col_idx   <= w_col_nx;
            r_cand_col  <= w_cand_col_nx;
            r_cand_row  <= w_cand_row_nx;
            r_cnt       <= w_cnt_nx;
            r_key_valid <= w_valid_nx;
            r_key_code  <= w_code_nx;
            r_key_held  <= w_held_nx;
            r_hexx      <= w_hexx_nx;
            r_cols      <= en ? ~(4'b0001 << r_col_idx) : 4'b1111;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    // Auto-repeat interval counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rep <= 16'd0;
        end else begin
            r_rep <= w_rep_nx;
        end
    end
`endif

    assign cols      = r_cols;
    assign key_valid = r_key_valid;
    assign key_code  = r_key_code;
    assign key_held  = r_key_held;
    assign hexx      = r_hexx;

endmodule
